// File: rtl/data_memory_dump.sv
// rtl/data_memory_dump.sv - streams a range of data-memory words out as MSB-first bytes
module data_memory_dump #(
    parameter int DATA_MEM_SIZE = 64,
    parameter int ADDR_W        = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam int              ADDR_MASK  = DATA_MEM_SIZE - 1;
    localparam logic [ADDR_W:0] REMAIN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W:0]     remain_q;
    logic [31:0]         shift_q;
    logic [1:0]          byte_idx_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                xfer;
    logic                last_byte;
    logic                last_word;

    assign addr_inc  = (addr_q + 1'b1) & ADDR_MASK[ADDR_W-1:0];
    assign xfer      = (state == S_SEND) && out_ready;
    assign last_byte = (byte_idx_q == 2'd3);
    assign last_word = (remain_q == REMAIN_ONE);
    assign mem_addr  = mem_addr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode from state and registers only, never from out_ready.
    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_rd     = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = shift_q[31:24];
                out_last  = last_byte && last_word;
                if (xfer && last_byte) begin
                    state_next = last_word ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // mem_addr only moves on the edge that enters READ, so it holds between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= base;
                        remain_q <= count;
                        if (count != '0) begin
                            mem_addr_q <= base;
                        end
                    end
                end
                S_LOAD: begin
                    shift_q    <= mem_rdata;
                    byte_idx_q <= 2'd0;
                end
                S_SEND: begin
                    if (xfer) begin
                        shift_q    <= {shift_q[23:0], 8'h00};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            remain_q <= remain_q - 1'b1;
                            addr_q   <= addr_inc;
                            if (!last_word) begin
                                mem_addr_q <= addr_inc;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_dump.sv
// tb/tb_data_memory_dump.sv - table-driven and sequence checks for data_memory_dump
module tb_data_memory_dump;

    logic        clock;
    logic        reset;
    logic        start;
    logic [5:0]  base;
    logic [6:0]  count;
    logic        mem_rd;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [64];
    int          errors = 0;
    int          checks = 0;

    data_memory_dump #(.DATA_MEM_SIZE(64), .ADDR_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [5:0]  base;
        logic [6:0]  cnt;
        int          mode;      // 0 always ready, 1 stall then toggle, 2 random
        bit          restart;
        logic [95:0] exp_bytes; // first byte at the top
        logic [17:0] exp_addrs; // first address at the top
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        logic [7:0] byte_q[$];
        bit         last_q[$];
        logic [5:0] addr_q[$];
        int         stall_err = 0;
        int         n_last = 0;
        bit         saw_done = 0;
        bit         prev_stall = 0;
        logic [7:0] prev_data = 0;
        logic [7:0] eb;
        logic [5:0] ea;
        @(negedge clock);
        start = 1'b1;
        base = vecs[i].base;
        count = vecs[i].cnt;
        out_ready = 1'b1;
        for (int c = 1; c < 400 && !saw_done; c++) begin
            @(negedge clock);
            if (vecs[i].restart && (c == 4 || c == 5)) start = 1'b1;
            else start = 1'b0;
            case (vecs[i].mode)
                1: out_ready = (c < 3) ? 1'b1 : (c <= 5) ? 1'b0 : (((c - 6) % 2) == 0);
                2: out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            if (mem_rd) addr_q.push_back(mem_addr);
            if (out_valid && out_ready) begin
                byte_q.push_back(out_data);
                last_q.push_back(out_last);
                if (out_last) n_last++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) saw_done = 1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check($sformatf("v%0d_done_seen", i), saw_done, 1);
        check($sformatf("v%0d_nbytes", i), byte_q.size(), 4 * vecs[i].cnt);
        check($sformatf("v%0d_naddrs", i), addr_q.size(), vecs[i].cnt);
        check($sformatf("v%0d_stall_stable", i), stall_err, 0);
        check($sformatf("v%0d_nlast", i), n_last, (vecs[i].cnt != 0) ? 1 : 0);
        for (int j = 0; j < byte_q.size() && j < 12; j++) begin
            eb = vecs[i].exp_bytes[95 - 8 * j -: 8];
            check($sformatf("v%0d_byte%0d", i, j), byte_q[j], eb);
        end
        if (last_q.size() > 0)
            check($sformatf("v%0d_last_on_final", i), last_q[last_q.size() - 1], 1);
        for (int k = 0; k < addr_q.size() && k < 3; k++) begin
            ea = vecs[i].exp_addrs[17 - 6 * k -: 6];
            check($sformatf("v%0d_addr%0d", i, k), addr_q[k], ea);
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int a = 0; a < 64; a++) mem[a] = 32'h0;
        mem[0]  = 32'h00000001;
        mem[2]  = 32'h8C220004;
        mem[10] = 32'h12345678;
        mem[11] = 32'h9ABCDEF0;
        mem[62] = 32'hCAFEF00D;
        mem[63] = 32'hDEADBEEF;
        mem_rdata = 32'h0;

        vecs[0] = '{6'd2,  7'd1, 0, 1'b0, {32'h8C220004, 64'h0}, {6'd2, 12'd0}};
        vecs[1] = '{6'd2,  7'd1, 1, 1'b0, {32'h8C220004, 64'h0}, {6'd2, 12'd0}};
        vecs[2] = '{6'd63, 7'd2, 0, 1'b0, {64'hDEADBEEF_00000001, 32'h0}, {6'd63, 6'd0, 6'd0}};
        vecs[3] = '{6'd63, 7'd2, 2, 1'b0, {64'hDEADBEEF_00000001, 32'h0}, {6'd63, 6'd0, 6'd0}};
        vecs[4] = '{6'd10, 7'd2, 0, 1'b1, {64'h12345678_9ABCDEF0, 32'h0}, {6'd10, 6'd11, 6'd0}};
        vecs[5] = '{6'd5,  7'd0, 0, 1'b0, 96'h0, 18'h0};
        vecs[6] = '{6'd62, 7'd3, 1, 1'b0, 96'hCAFEF00D_DEADBEEF_00000001, {6'd62, 6'd63, 6'd0}};
        vecs[7] = '{6'd0,  7'd1, 0, 1'b0, {32'h00000001, 64'h0}, {6'd0, 12'd0}};

        reset = 1'b0;
        start = 1'b1;
        base = 6'd7;
        count = 7'd3;
        out_ready = 1'b1;
        #12;
        check("rst_outputs", {mem_rd, mem_addr, out_valid, out_data, out_last, busy, done}, 0);
        @(negedge clock);
        check("rst_outputs_late", {mem_rd, out_valid, busy, done}, 0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_idle", {mem_rd, out_valid, busy, done}, 0);

        // Cycle-exact single word.
        w = mem[2];
        @(negedge clock);
        start = 1'b1; base = 6'd2; count = 7'd1; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("c1_mem_rd", mem_rd, 1);
        check("c1_mem_addr", mem_addr, 2);
        check("c1_busy", busy, 1);
        @(negedge clock);
        check("c2_idle_out", {mem_rd, out_valid}, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check($sformatf("c%0d_valid", j + 3), out_valid, 1);
            check($sformatf("c%0d_data", j + 3), out_data, w[31 - 8 * j -: 8]);
            check($sformatf("c%0d_last", j + 3), out_last, (j == 3) ? 1 : 0);
        end
        @(negedge clock);
        check("c7_done", {done, out_valid}, 2'b10);
        check("c7_mem_addr_held", mem_addr, 2);
        @(negedge clock);
        check("c8_idle", {busy, done}, 0);

        // Zero count.
        @(negedge clock);
        start = 1'b1; base = 6'd5; count = 7'd0;
        @(negedge clock);
        start = 1'b0;
        check("z1_done", {done, busy, mem_rd, out_valid}, 4'b1100);
        @(negedge clock);
        check("z2_idle", {done, busy}, 0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset in the middle of sending byte 1.
        @(negedge clock);
        start = 1'b1; base = 6'd2; count = 7'd4; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("mr_byte1", {out_valid, out_data}, {1'b1, 8'h22});
        #2;
        reset = 1'b0;
        #1;
        check("mr_async", {out_valid, busy, out_data, out_last, mem_rd, mem_addr, done}, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mr_idle_after", {busy, out_valid}, 0);
        run_vec(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
